// File: rtl/instruction_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch front end.
// Holds the word/PC widths, FSM state encoding and the FIFO entry layout.
package instruction_fetch_unit_pkg;

    localparam int DATA_WIDTH        = 32;
    localparam int INSTRUCTION_WIDTH = 32;

    localparam logic [DATA_WIDTH-1:0] PC_STEP = 32'd4;

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2
    } ifu_state_e;

    typedef struct packed {
        logic [INSTRUCTION_WIDTH-1:0] inst;
        logic [DATA_WIDTH-1:0]        pc;
    } fetch_entry_t;

    function automatic logic [DATA_WIDTH-1:0] align_word(input logic [DATA_WIDTH-1:0] addr);
        return {addr[DATA_WIDTH-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/instruction_fetch_unit_fetch_fifo.sv
// Generic synchronous FIFO with clear; data visible one cycle after push, no bypass.
// No internal backpressure: caller must not push when full unless popping the same cycle.
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_dat,
    input  logic                       pop,
    input  logic                       clear,
    output logic [WIDTH-1:0]           pop_dat,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push;
    logic             do_pop;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_dat;
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign count   = count_q;
    // Head reads as zero when empty so the decoder never sees stale words.
    assign pop_dat = empty ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch front end: PC, credit-limited word requests, in-order response queue, redirect flush.
// Latency request->inst_valid = memory latency + 1; inst_ready low stalls the head and throttles requests via credits.
module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
#(
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = 32'h0000_0000,
    parameter int                    FIFO_DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         reset_n,
    output logic                         imem_req_valid,
    input  logic                         imem_req_ready,
    output logic [DATA_WIDTH-1:0]        imem_req_addr,
    input  logic                         imem_resp_valid,
    input  logic [INSTRUCTION_WIDTH-1:0] imem_resp_data,
    input  logic                         redirect_valid,
    input  logic [DATA_WIDTH-1:0]        redirect_pc,
    output logic                         inst_valid,
    input  logic                         inst_ready,
    output logic [INSTRUCTION_WIDTH-1:0] inst_out,
    output logic [DATA_WIDTH-1:0]        inst_pc,
    output logic                         fetch_misaligned
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    ifu_state_e            state_q, state_d;
    logic [DATA_WIDTH-1:0] pc_q, pc_d;
    logic [DATA_WIDTH-1:0] resp_pc_q, resp_pc_d;
    logic [CW-1:0]         in_flight_q, in_flight_d;
    logic [CW-1:0]         drop_cnt_q, drop_cnt_d;
    logic                  misaligned_q, misaligned_d;

    logic [CW-1:0]         fifo_count;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  fifo_push;
    logic                  fifo_pop;
    fetch_entry_t          push_ent;
    fetch_entry_t          head_ent;
    logic [CW:0]           credits_used;
    logic                  req_fire;

    // Queue occupancy plus outstanding requests never exceeds FIFO_DEPTH, so responses always fit.
    always_comb begin
        credits_used   = {1'b0, fifo_count} + {1'b0, in_flight_q};
        imem_req_valid = (state_q == S_RUN) && !redirect_valid
                         && (credits_used < (CW+1)'(FIFO_DEPTH));
        req_fire       = imem_req_valid && imem_req_ready;
        inst_valid     = !fifo_empty && !redirect_valid;
        fifo_pop       = inst_valid && inst_ready;
        fifo_push      = imem_resp_valid && !redirect_valid && (drop_cnt_q == '0);
        push_ent.inst  = imem_resp_data;
        push_ent.pc    = resp_pc_q;
    end

    always_comb begin
        pc_d         = pc_q;
        resp_pc_d    = resp_pc_q;
        drop_cnt_d   = drop_cnt_q;
        in_flight_d  = in_flight_q + CW'(req_fire) - CW'(imem_resp_valid);
        misaligned_d = redirect_valid && (|redirect_pc[1:0]);
        if (redirect_valid) begin
            pc_d       = align_word(redirect_pc);
            resp_pc_d  = align_word(redirect_pc);
            // Everything still outstanding after this cycle belongs to the old path.
            drop_cnt_d = in_flight_d;
        end else begin
            if (req_fire) begin
                pc_d = pc_q + PC_STEP;
            end
            if (fifo_push) begin
                resp_pc_d = resp_pc_q + PC_STEP;
            end
            if (imem_resp_valid && (drop_cnt_q != '0)) begin
                drop_cnt_d = drop_cnt_q - CW'(1);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_BOOT:  state_d = S_RUN;
            S_RUN:   if (redirect_valid && (drop_cnt_d != '0)) state_d = S_FLUSH;
            S_FLUSH: if (drop_cnt_d == '0) state_d = S_RUN;
            default: state_d = S_BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_BOOT;
            pc_q         <= RESET_PC;
            resp_pc_q    <= RESET_PC;
            in_flight_q  <= '0;
            drop_cnt_q   <= '0;
            misaligned_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            resp_pc_q    <= resp_pc_d;
            in_flight_q  <= in_flight_d;
            drop_cnt_q   <= drop_cnt_d;
            misaligned_q <= misaligned_d;
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(fetch_entry_t))
    ) u_fifo (
        .clk      (clk),
        .rst_n    (reset_n),
        .push     (fifo_push),
        .push_dat (push_ent),
        .pop      (fifo_pop),
        .clear    (redirect_valid),
        .pop_dat  (head_ent),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    assign imem_req_addr    = pc_q;
    assign inst_out         = head_ent.inst;
    assign inst_pc          = head_ent.pc;
    assign fetch_misaligned = misaligned_q;

    a_no_overflow: assert property (@(posedge clk) disable iff (!reset_n)
        !(fifo_push && fifo_full && !fifo_pop));

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit with an in-order, fixed-latency memory model.
module tb_instruction_fetch_unit;
    import instruction_fetch_unit_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_out;
    logic [31:0] inst_pc;
    logic        fetch_misaligned;

    int checks   = 0;
    int failures = 0;
    int cyc, lat, first_dlv, mis_cnt;
    logic [31:0] mq_addr[$];
    int          mq_due[$];
    logic [31:0] req_log[$];
    logic [31:0] dlv_pc[$];
    logic [31:0] dlv_dat[$];
    logic        o_req_vld, o_inst_vld, o_mis;
    logic [31:0] o_req_addr, o_inst_pc;

    always #5 clk = ~clk;

    instruction_fetch_unit #(.RESET_PC(32'h0), .FIFO_DEPTH(2)) dut (
        .clk(clk), .reset_n(reset_n),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
        .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_out(inst_out), .inst_pc(inst_pc),
        .fetch_misaligned(fetch_misaligned)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    // One clock cycle: memory answers, outputs are observed, then the edge is taken.
    task automatic step();
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        if (mq_due.size() > 0 && mq_due[0] <= cyc) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = mem_word(mq_addr[0]);
            void'(mq_addr.pop_front());
            void'(mq_due.pop_front());
        end
        #1;
        o_req_vld  = imem_req_valid;
        o_req_addr = imem_req_addr;
        o_inst_vld = inst_valid;
        o_inst_pc  = inst_pc;
        o_mis      = fetch_misaligned;
        if (fetch_misaligned) mis_cnt++;
        if (imem_req_valid && imem_req_ready) begin
            mq_addr.push_back(imem_req_addr);
            mq_due.push_back(cyc + lat);
            req_log.push_back(imem_req_addr);
        end
        if (inst_valid && inst_ready) begin
            dlv_pc.push_back(inst_pc);
            dlv_dat.push_back(inst_out);
            if (first_dlv < 0) first_dlv = cyc;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Reset and memory flush, leaving the DUT one edge into S_RUN at cycle 0.
    task automatic do_reset();
        reset_n         = 1'b0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        redirect_valid  = 1'b0;
        redirect_pc     = '0;
        imem_req_ready  = 1'b1;
        inst_ready      = 1'b1;
        mq_addr.delete(); mq_due.delete(); req_log.delete(); dlv_pc.delete(); dlv_dat.delete();
        cyc = 0; first_dlv = -1; mis_cnt = 0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b1; imem_req_ready = 1'b1; imem_resp_valid = 1'b0; imem_resp_data = '0;
        redirect_valid = 1'b0; redirect_pc = '0; inst_ready = 1'b1;
        #1 reset_n = 1'b0;
        #2;
        checks++; if (imem_req_valid !== 1'b0) begin failures++; $display("FAIL rst_req_vld got=%b want=0", imem_req_valid); end
        checks++; if (imem_req_addr !== 32'h0) begin failures++; $display("FAIL rst_req_addr got=%h want=0", imem_req_addr); end
        checks++; if (inst_valid !== 1'b0) begin failures++; $display("FAIL rst_inst_vld got=%b want=0", inst_valid); end
        checks++; if (inst_out !== 32'h0 || inst_pc !== 32'h0) begin failures++; $display("FAIL rst_inst got=%h/%h want=0/0", inst_out, inst_pc); end
        checks++; if (fetch_misaligned !== 1'b0) begin failures++; $display("FAIL rst_mis got=%b want=0", fetch_misaligned); end
        checks++; if (dut.state_q !== S_BOOT) begin failures++; $display("FAIL rst_state got=%0d want=%0d", dut.state_q, S_BOOT); end
        @(posedge clk);
        #1 reset_n = 1'b1;
        checks++; if (imem_req_valid !== 1'b0) begin failures++; $display("FAIL boot_req_vld got=%b want=0", imem_req_valid); end
        @(posedge clk);
        #1;
        checks++; if (dut.state_q !== S_RUN) begin failures++; $display("FAIL boot_to_run got=%0d want=%0d", dut.state_q, S_RUN); end
        checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin failures++; $display("FAIL run_first_req got=%b/%h want=1/0", imem_req_valid, imem_req_addr); end
    endtask

    task automatic test_basic();
        do_reset(); lat = 1;
        repeat (12) step();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (req_log.size() <= i || req_log[i] !== 32'(4 * i)) begin
                failures++; $display("FAIL basic_req_addr[%0d] got=%h want=%h", i, (req_log.size() > i) ? req_log[i] : 32'hx, 32'(4 * i));
            end
        end
        checks++; if (first_dlv != 2) begin failures++; $display("FAIL basic_first_latency got=%0d want=2", first_dlv); end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (dlv_pc.size() <= i || dlv_pc[i] !== 32'(4 * i) || dlv_dat[i] !== mem_word(32'(4 * i))) begin
                failures++; $display("FAIL basic_deliver[%0d] got=%h want pc=%h", i, (dlv_pc.size() > i) ? dlv_pc[i] : 32'hx, 32'(4 * i));
            end
        end
    endtask

    task automatic test_stall();
        do_reset(); lat = 1; inst_ready = 1'b0;
        repeat (10) step();
        checks++; if (o_req_vld !== 1'b0) begin failures++; $display("FAIL stall_req_vld got=%b want=0", o_req_vld); end
        checks++; if (dut.in_flight_q !== 2'd0) begin failures++; $display("FAIL stall_in_flight got=%0d want=0", dut.in_flight_q); end
        checks++; if (dut.u_fifo.count_q !== 2'd2) begin failures++; $display("FAIL stall_fifo_count got=%0d want=2", dut.u_fifo.count_q); end
        checks++; if (o_inst_vld !== 1'b1 || o_inst_pc !== 32'h0) begin failures++; $display("FAIL stall_head got=%b/%h want=1/0", o_inst_vld, o_inst_pc); end
        checks++; if (req_log.size() != 2) begin failures++; $display("FAIL stall_req_count got=%0d want=2", req_log.size()); end
        inst_ready = 1'b1;
        repeat (10) step();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (dlv_pc.size() <= i || dlv_pc[i] !== 32'(4 * i)) begin
                failures++; $display("FAIL stall_release[%0d] got=%h want=%h", i, (dlv_pc.size() > i) ? dlv_pc[i] : 32'hx, 32'(4 * i));
            end
        end
    endtask

    task automatic test_redirect_flush();
        do_reset(); lat = 3;
        repeat (2) step();
        redirect_valid = 1'b1; redirect_pc = 32'h100;
        step();
        redirect_valid = 1'b0;
        checks++; if (dut.state_q !== S_FLUSH || dut.drop_cnt_q !== 2'd2) begin failures++; $display("FAIL flush_enter got=%0d/%0d want=%0d/2", dut.state_q, dut.drop_cnt_q, S_FLUSH); end
        step();
        checks++; if (o_req_vld !== 1'b0 || dut.drop_cnt_q !== 2'd1) begin failures++; $display("FAIL flush_mid got=%b/%0d want=0/1", o_req_vld, dut.drop_cnt_q); end
        step();
        checks++; if (dut.state_q !== S_RUN || dut.drop_cnt_q !== 2'd0) begin failures++; $display("FAIL flush_exit got=%0d/%0d want=%0d/0", dut.state_q, dut.drop_cnt_q, S_RUN); end
        repeat (8) step();
        checks++; if (req_log.size() < 3 || req_log[2] !== 32'h100) begin failures++; $display("FAIL flush_new_req got=%h want=100", (req_log.size() > 2) ? req_log[2] : 32'hx); end
        checks++; if (dlv_pc.size() < 1 || dlv_pc[0] !== 32'h100 || dlv_dat[0] !== mem_word(32'h100)) begin failures++; $display("FAIL flush_first_pc got=%h want=100", (dlv_pc.size() > 0) ? dlv_pc[0] : 32'hx); end
        checks++; if (first_dlv != 9) begin failures++; $display("FAIL flush_first_cycle got=%0d want=9", first_dlv); end
    endtask

    task automatic test_redirect_resp();
        do_reset(); lat = 3;
        repeat (4) step();
        redirect_valid = 1'b1; redirect_pc = 32'h200;
        step();
        redirect_valid = 1'b0;
        checks++; if (o_inst_vld !== 1'b0 || dlv_pc.size() != 0) begin failures++; $display("FAIL rresp_inst_vld got=%b/%0d want=0/0", o_inst_vld, dlv_pc.size()); end
        checks++; if (dut.state_q !== S_RUN || dut.drop_cnt_q !== 2'd0 || dut.in_flight_q !== 2'd0) begin failures++; $display("FAIL rresp_counters got=%0d/%0d/%0d want=%0d/0/0", dut.state_q, dut.drop_cnt_q, dut.in_flight_q, S_RUN); end
        checks++; if (dut.u_fifo.count_q !== 2'd0) begin failures++; $display("FAIL rresp_fifo_cleared got=%0d want=0", dut.u_fifo.count_q); end
        repeat (7) step();
        checks++; if (dlv_pc.size() < 1 || dlv_pc[0] !== 32'h200) begin failures++; $display("FAIL rresp_first_pc got=%h want=200", (dlv_pc.size() > 0) ? dlv_pc[0] : 32'hx); end
    endtask

    task automatic test_double_redirect();
        logic found;
        do_reset(); lat = 3;
        repeat (2) step();
        redirect_valid = 1'b1; redirect_pc = 32'h200;
        step();
        redirect_pc = 32'h300;
        step();
        redirect_valid = 1'b0;
        checks++; if (dut.state_q !== S_FLUSH || dut.drop_cnt_q !== 2'd1) begin failures++; $display("FAIL dbl_flush got=%0d/%0d want=%0d/1", dut.state_q, dut.drop_cnt_q, S_FLUSH); end
        step();
        checks++; if (dut.state_q !== S_RUN) begin failures++; $display("FAIL dbl_exit got=%0d want=%0d", dut.state_q, S_RUN); end
        repeat (8) step();
        found = 1'b0;
        foreach (req_log[i]) if (req_log[i] == 32'h200) found = 1'b1;
        checks++; if (found !== 1'b0) begin failures++; $display("FAIL dbl_no_200_fetch got=%b want=0", found); end
        checks++; if (dlv_pc.size() < 2 || dlv_pc[0] !== 32'h300 || dlv_pc[1] !== 32'h304) begin failures++; $display("FAIL dbl_deliver got=%h want=300", (dlv_pc.size() > 0) ? dlv_pc[0] : 32'hx); end
    endtask

    task automatic test_misaligned();
        do_reset(); lat = 1;
        step();
        redirect_valid = 1'b1; redirect_pc = 32'h102;
        step();
        redirect_valid = 1'b0;
        checks++; if (fetch_misaligned !== 1'b1) begin failures++; $display("FAIL mis_pulse got=%b want=1", fetch_misaligned); end
        checks++; if (dut.state_q !== S_RUN) begin failures++; $display("FAIL mis_state got=%0d want=%0d", dut.state_q, S_RUN); end
        step();
        checks++; if (o_req_vld !== 1'b1 || o_req_addr !== 32'h100) begin failures++; $display("FAIL mis_req got=%b/%h want=1/100", o_req_vld, o_req_addr); end
        checks++; if (fetch_misaligned !== 1'b0) begin failures++; $display("FAIL mis_clear got=%b want=0", fetch_misaligned); end
        repeat (6) step();
        checks++; if (mis_cnt != 1) begin failures++; $display("FAIL mis_count got=%0d want=1", mis_cnt); end
        checks++; if (dlv_pc.size() < 1 || dlv_pc[0] !== 32'h100) begin failures++; $display("FAIL mis_first_pc got=%h want=100", (dlv_pc.size() > 0) ? dlv_pc[0] : 32'hx); end
    endtask

    task automatic test_wrap();
        do_reset(); lat = 1;
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        step();
        redirect_valid = 1'b0;
        repeat (6) step();
        checks++; if (req_log.size() < 2 || req_log[0] !== 32'hFFFF_FFFC || req_log[1] !== 32'h0) begin failures++; $display("FAIL wrap_req got=%h,%h want=fffffffc,0", (req_log.size() > 0) ? req_log[0] : 32'hx, (req_log.size() > 1) ? req_log[1] : 32'hx); end
        checks++; if (dlv_pc.size() < 2 || dlv_pc[0] !== 32'hFFFF_FFFC || dlv_pc[1] !== 32'h0) begin failures++; $display("FAIL wrap_deliver got=%h want=fffffffc", (dlv_pc.size() > 0) ? dlv_pc[0] : 32'hx); end
    endtask

    task automatic test_reset_mid();
        do_reset(); lat = 1;
        repeat (3) step();
        imem_resp_valid = 1'b0;
        reset_n = 1'b0;
        #1;
        checks++; if (imem_req_valid !== 1'b0 || imem_req_addr !== 32'h0) begin failures++; $display("FAIL mid_rst_req got=%b/%h want=0/0", imem_req_valid, imem_req_addr); end
        checks++; if (inst_valid !== 1'b0 || inst_pc !== 32'h0) begin failures++; $display("FAIL mid_rst_inst got=%b/%h want=0/0", inst_valid, inst_pc); end
        checks++; if (dut.state_q !== S_BOOT || dut.in_flight_q !== 2'd0) begin failures++; $display("FAIL mid_rst_state got=%0d/%0d want=%0d/0", dut.state_q, dut.in_flight_q, S_BOOT); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_redirect_flush();
        test_redirect_resp();
        test_double_redirect();
        test_misaligned();
        test_wrap();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
